// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Owns the PC, drives the
// combinational instruction memory, and buffers up to two {pc, instr}
// pairs for decode over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   imem_pc             fetch address to instruction memory (= fetch_pc)
//   imem_instruction    instruction word for imem_pc, same cycle
//   redirect_valid/pc   replace the fetch stream (branch, jal, jalr)
//   out_valid/ready     decode handshake for the buffer head
//   out_pc/instruction  head entry; held while out_valid=0
//   fault, fault_cause  fetch halted: 01 misaligned, 10 out of range
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [31:0] ent_pc_q  [2];
    logic [31:0] ent_pc_d  [2];
    logic [31:0] ent_ins_q [2];
    logic [31:0] ent_ins_d [2];
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_ins_q, out_ins_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic        pop;
    logic        push;
    logic        pc_legal;
    logic        rd_misaligned;
    logic        rd_range_ok;
    logic [31:0] pc_inc;

    assign imem_pc         = pc_q;
    assign out_valid       = (cnt_q != 2'd0);
    assign out_pc          = out_pc_q;
    assign out_instruction = out_ins_q;
    assign fault           = fault_q;
    assign fault_cause     = cause_q;

    assign pc_legal      = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);
    assign rd_misaligned = (redirect_pc[1:0] != 2'b00);
    assign rd_range_ok   = (redirect_pc < PC_LIMIT);
    assign pc_inc        = pc_q + 32'd4;

    assign pop  = out_valid & out_ready;
    assign push = pc_legal & ~fault_q & ~redirect_valid
                & ((cnt_q < 2'd2) | pop);

    always_comb begin
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        ent_pc_d  = ent_pc_q;
        ent_ins_d = ent_ins_q;
        out_pc_d  = out_pc_q;
        out_ins_d = out_ins_q;
        fault_d   = fault_q;
        cause_d   = cause_q;

        if (redirect_valid) begin
            // Flush: buffered entries and any same-cycle pop are discarded.
            cnt_d  = 2'd0;
            head_d = 1'b0;
            tail_d = 1'b0;
            pc_d   = redirect_pc;
            if (rd_misaligned) begin
                fault_d = 1'b1;
                cause_d = CAUSE_ALIGN;
            end else if (!rd_range_ok) begin
                fault_d = 1'b1;
                cause_d = CAUSE_RANGE;
            end else begin
                fault_d = 1'b0;
                cause_d = CAUSE_NONE;
            end
        end else begin
            if (push) begin
                ent_pc_d[tail_q]  = pc_q;
                ent_ins_d[tail_q] = imem_instruction;
                tail_d            = ~tail_q;
                pc_d              = pc_inc;
                // Sequential run stepped past the last word.
                if (pc_inc == PC_LIMIT) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_RANGE;
                end
            end
            if (pop) begin
                head_d = ~head_q;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
            // Catches an illegal RESET_PC; redirects fault above.
            if (!fault_q && !pc_legal) begin
                fault_d = 1'b1;
                cause_d = (pc_q[1:0] != 2'b00) ? CAUSE_ALIGN
                                               : CAUSE_RANGE;
            end
        end

        // Output registers track the next head, holding when empty.
        if (cnt_d != 2'd0) begin
            out_pc_d  = ent_pc_d[head_d];
            out_ins_d = ent_ins_d[head_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            cnt_q     <= 2'd0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            ent_pc_q  <= '{default: 32'd0};
            ent_ins_q <= '{default: 32'd0};
            out_pc_q  <= 32'd0;
            out_ins_q <= 32'd0;
            fault_q   <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            ent_pc_q  <= ent_pc_d;
            ent_ins_q <= ent_ins_d;
            out_pc_q  <= out_pc_d;
            out_ins_q <= out_ins_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a combinational
// instruction memory model derived from the fetch address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        fault;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instruction  (out_instruction),
        .fault            (fault),
        .fault_cause      (fault_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    assign imem_instruction = instr_of(imem_pc);

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_ins"}, out_instruction, instr_of(pc));
    endtask

    task automatic fstate(input string tag,
                          input logic f, input logic [1:0] c);
        chk({tag, "_fault"}, {31'd0, fault}, {31'd0, f});
        chk({tag, "_cause"}, {30'd0, fault_cause}, {30'd0, c});
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_ins", out_instruction, 32'd0);
        chk("rst_imem", imem_pc, 32'd0);
        fstate("rst", 1'b0, 2'b00);

        // Streaming with decode always ready.
        step();
        rst_n = 1'b1;
        step(); head("s0", 32'h0);
        step(); head("s1", 32'h4);
        step(); head("s2", 32'h8);
        step(); head("s3", 32'hC);

        // Backpressure: buffer fills to two and PC stalls.
        rst_n = 1'b0;
        #2;
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        step(); head("bp0", 32'h0);
        step();
        step();
        step();
        step(); head("bp4", 32'h0);
        chk("bp_imem", imem_pc, 32'h8);
        out_ready = 1'b1;
        step(); head("rel0", 32'h4);
        step(); head("rel1", 32'h8);
        step(); head("rel2", 32'hC);

        // Redirect with two entries buffered (0xC, 0x10).
        redirect_valid = 1'b1;
        redirect_pc    = 32'h74;
        step();
        redirect_valid = 1'b0;
        chk("rd_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_imem", imem_pc, 32'h74);
        fstate("rd", 1'b0, 2'b00);
        step(); head("rd0", 32'h74);
        step(); head("rd1", 32'h78);

        // Misaligned redirect, then out-of-range, then legal recovery.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h76;
        step();
        redirect_valid = 1'b0;
        fstate("mis", 1'b1, 2'b01);
        chk("mis_valid", {31'd0, out_valid}, 32'd0);
        chk("mis_imem", imem_pc, 32'h76);
        step();
        chk("mis_hold", imem_pc, 32'h76);
        chk("mis_valid2", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        fstate("oor", 1'b1, 2'b10);
        chk("oor_imem", imem_pc, 32'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        fstate("rec", 1'b0, 2'b00);
        step(); head("rec0", 32'h80);

        // Sequential overrun at the end of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hF4;
        step();
        redirect_valid = 1'b0;
        step(); head("end0", 32'hF4);
        fstate("end0", 1'b0, 2'b00);
        step(); head("end1", 32'hF8);
        step(); head("end2", 32'hFC);
        fstate("end2", 1'b1, 2'b10);
        step();
        chk("end_valid", {31'd0, out_valid}, 32'd0);
        chk("end_imem", imem_pc, 32'h100);
        fstate("end3", 1'b1, 2'b10);
        step();
        chk("end_valid2", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with the buffer full.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        redirect_valid = 1'b0;
        step();
        step(); head("ar_full", 32'h10);
        chk("ar_imem_pre", imem_pc, 32'h18);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_imem", imem_pc, 32'h0);
        chk("ar_pc", out_pc, 32'h0);
        fstate("ar", 1'b0, 2'b00);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step(); head("ar0", 32'h0);
        step(); head("ar1", 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
